// File: rtl/systolic_row_feeder.sv
// rtl/systolic_row_feeder.sv - row FIFO and sequencer that feeds the systolic-array input parser
//
// Buffers matrix rows behind a valid/ready handshake and streams one row per
// cycle into the parser lanes. Each block ends with FULL_SIZE zero rows that
// flush the parser's skew pipeline. A tile-mode change is applied only once
// the pipeline is empty, and is followed by HALF_SIZE idle settle cycles.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_valid / s_ready   upstream row handshake
//   s_data_0, s_data_1  row for the in_0 lane, second row (tile mode only)
//   s_last              last row of a block
//   tile_req            requested tile mode
//   tile                tile mode currently applied to the parser
//   enable              parser shift enable
//   out_0, out_1        rows to parser in_0 / in_1
//   busy                sequencer active or rows buffered
//   blocks_done         completed-block counter, wraps at 2^16

module systolic_row_feeder #(
    parameter int FULL_SIZE  = 8,
    parameter int HALF_SIZE  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [FULL_SIZE*DATA_WIDTH-1:0] s_data_0,
    input  logic [FULL_SIZE*DATA_WIDTH-1:0] s_data_1,
    input  logic                            s_last,
    input  logic                            tile_req,
    output logic                            tile,
    output logic                            enable,
    output logic [FULL_SIZE*DATA_WIDTH-1:0] out_0,
    output logic [FULL_SIZE*DATA_WIDTH-1:0] out_1,
    output logic                            busy,
    output logic [15:0]                     blocks_done
);

    localparam int ROW_W   = FULL_SIZE * DATA_WIDTH;
    localparam int ENTRY_W = 2 * ROW_W + 1;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int DR_W    = $clog2(FULL_SIZE + 1);
    localparam int SW_W    = $clog2(HALF_SIZE + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_SWITCH
    } state_t;

    // ------------------------------------------------------------------
    // Row FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic               head_last;
    logic [ROW_W-1:0]   head_d0;
    logic [ROW_W-1:0]   head_d1;

    assign s_ready   = (count < CNT_W'(DEPTH));
    assign push      = s_valid && s_ready;
    assign head      = mem[rd_ptr];
    assign head_last = head[ENTRY_W-1];
    assign head_d1   = head[2*ROW_W-1:ROW_W];
    assign head_d0   = head[ROW_W-1:0];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s_last, s_data_1, s_data_0};
        end
    end

    // Pop decisions read the registered count, so a row written at one
    // edge cannot leave before the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t          state;
    state_t          state_d;
    logic [DR_W-1:0] dr_cnt;
    logic [DR_W-1:0] dr_cnt_d;
    logic [SW_W-1:0] sw_cnt;
    logic [SW_W-1:0] sw_cnt_d;
    logic            tile_d;
    logic            enable_d;
    logic            load_row;
    logic            clear_out;
    logic            block_inc;
    logic            rows_avail;

    assign rows_avail = (count != '0);
    assign busy       = (state != S_IDLE) || rows_avail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        dr_cnt_d  = dr_cnt;
        sw_cnt_d  = sw_cnt;
        tile_d    = tile;
        enable_d  = enable;
        pop       = 1'b0;
        load_row  = 1'b0;
        clear_out = 1'b0;
        block_inc = 1'b0;

        case (state)
            S_IDLE: begin
                if (tile_req != tile) begin
                    // Pipeline is already empty here, so the mode can flip now.
                    tile_d    = tile_req;
                    state_d   = S_SWITCH;
                    sw_cnt_d  = '0;
                    enable_d  = 1'b0;
                    clear_out = 1'b1;
                end else if (rows_avail) begin
                    pop      = 1'b1;
                    load_row = 1'b1;
                    enable_d = 1'b1;
                    if (head_last) begin
                        state_d  = S_DRAIN;
                        dr_cnt_d = '0;
                    end else begin
                        state_d = S_STREAM;
                    end
                end else begin
                    enable_d  = 1'b0;
                    clear_out = 1'b1;
                end
            end

            S_STREAM: begin
                if (rows_avail) begin
                    pop      = 1'b1;
                    load_row = 1'b1;
                    enable_d = 1'b1;
                    if (head_last) begin
                        state_d  = S_DRAIN;
                        dr_cnt_d = '0;
                    end
                end else begin
                    // Underflow stalls the parser: outputs hold, no shift.
                    enable_d = 1'b0;
                end
            end

            S_DRAIN: begin
                clear_out = 1'b1;
                enable_d  = 1'b1;
                dr_cnt_d  = dr_cnt + DR_W'(1);
                if (dr_cnt == DR_W'(FULL_SIZE - 1)) begin
                    block_inc = 1'b1;
                    if (tile_req != tile) begin
                        tile_d   = tile_req;
                        state_d  = S_SWITCH;
                        sw_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_SWITCH: begin
                clear_out = 1'b1;
                enable_d  = 1'b0;
                sw_cnt_d  = sw_cnt + SW_W'(1);
                if (sw_cnt == SW_W'(HALF_SIZE - 1)) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dr_cnt      <= '0;
            sw_cnt      <= '0;
            tile        <= 1'b0;
            enable      <= 1'b0;
            out_0       <= '0;
            out_1       <= '0;
            blocks_done <= '0;
        end else begin
            dr_cnt <= dr_cnt_d;
            sw_cnt <= sw_cnt_d;
            tile   <= tile_d;
            enable <= enable_d;
            if (load_row) begin
                // Rows are only loaded while tile is stable, so the current
                // mode decides whether the second lane is live.
                out_0 <= head_d0;
                out_1 <= tile ? head_d1 : '0;
            end else if (clear_out) begin
                out_0 <= '0;
                out_1 <= '0;
            end
            if (block_inc) begin
                blocks_done <= blocks_done + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_systolic_row_feeder.sv
// tb/tb_systolic_row_feeder.sv - self-checking bench for systolic_row_feeder
module tb_systolic_row_feeder;

    localparam int FULL_SIZE  = 8;
    localparam int HALF_SIZE  = 4;
    localparam int DATA_WIDTH = 16;
    localparam int DEPTH      = 8;
    localparam int ROW_W      = FULL_SIZE * DATA_WIDTH;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [ROW_W-1:0] s_data_0;
    logic [ROW_W-1:0] s_data_1;
    logic             s_last;
    logic             tile_req;
    logic             tile;
    logic             enable;
    logic [ROW_W-1:0] out_0;
    logic [ROW_W-1:0] out_1;
    logic             busy;
    logic [15:0]      blocks_done;

    systolic_row_feeder #(
        .FULL_SIZE (FULL_SIZE),
        .HALF_SIZE (HALF_SIZE),
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data_0   (s_data_0),
        .s_data_1   (s_data_1),
        .s_last     (s_last),
        .tile_req   (tile_req),
        .tile       (tile),
        .enable     (enable),
        .out_0      (out_0),
        .out_1      (out_1),
        .busy       (busy),
        .blocks_done(blocks_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic mon_on = 1'b0;
    logic model_tile = 1'b0;
    int exp_blocks = 0;
    logic [2*ROW_W-1:0] exp_q[$];
    logic [2*ROW_W-1:0] mon_exp;

    typedef struct {
        logic v;
        logic last;
        int   in_sel;
        logic exp_en;
        int   exp_sel;
        int   exp_bd;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [ROW_W-1:0] lanes(input int base, input int step);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int i = 0; i < FULL_SIZE; i++) begin
            r[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(base + step * i);
        end
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] sel_row(input int sel);
        if (sel == 1) return lanes(1, 1);
        if (sel == 2) return lanes(9, 1);
        return '0;
    endfunction

    task automatic check(input string name, input logic [2*ROW_W-1:0] act,
                         input logic [2*ROW_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the parser must see, on enabled cycles, every accepted
    // row in order, followed by FULL_SIZE zero rows after each block's last row.
    always @(negedge clk) begin
        if (rst_n && mon_on && enable) begin
            if (exp_q.size() == 0) begin
                check("mon_unexpected_enable", enable, 1'b0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("mon_row", {out_1, out_0}, mon_exp);
            end
        end
        if (rst_n && s_valid && s_ready) begin
            if (s_last) exp_blocks++;
            if (mon_on) begin
                exp_q.push_back({(model_tile ? s_data_1 : {ROW_W{1'b0}}), s_data_0});
                if (s_last) begin
                    for (int i = 0; i < FULL_SIZE; i++) exp_q.push_back('0);
                end
            end
        end
    end

    task automatic send_row(input logic [ROW_W-1:0] d0, input logic [ROW_W-1:0] d1,
                            input logic last);
        logic acc;
        int n;
        s_valid  = 1'b1;
        s_data_0 = d0;
        s_data_1 = d1;
        s_last   = last;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            acc = s_ready;
            tick();
            n++;
        end
        check("send_accept", acc, 1'b1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        tick();
        tick();
        check("idle_reached", busy, 1'b0);
        check("queue_drained", exp_q.size(), 0);
        check("blocks_done", blocks_done, 16'(exp_blocks));
    endtask

    initial begin
        int accepts;
        logic rdy;

        rst_n    = 1'b1;
        s_valid  = 1'b0;
        s_data_0 = '0;
        s_data_1 = '0;
        s_last   = 1'b0;
        tile_req = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_s_ready", s_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_enable", enable, 1'b0);
        check("rst_tile", tile, 1'b0);
        check("rst_out_0", out_0, '0);
        check("rst_out_1", out_1, '0);
        check("rst_blocks_done", blocks_done, '0);
        tick();
        tick();
        rst_n = 1'b1;

        // Basic block, tile=0: A then B(last), 8 drain cycles, back to idle.
        tbl[0]  = '{1'b1, 1'b0, 1, 1'b0, 0, 0};
        tbl[1]  = '{1'b1, 1'b1, 2, 1'b1, 1, 0};
        tbl[2]  = '{1'b0, 1'b0, 0, 1'b1, 2, 0};
        for (int i = 3; i < 10; i++) tbl[i] = '{1'b0, 1'b0, 0, 1'b1, 0, 0};
        tbl[10] = '{1'b0, 1'b0, 0, 1'b1, 0, 1};
        tbl[11] = '{1'b0, 1'b0, 0, 1'b0, 0, 1};
        for (int i = 0; i < 12; i++) begin
            s_valid  = tbl[i].v;
            s_last   = tbl[i].last;
            s_data_0 = sel_row(tbl[i].in_sel);
            s_data_1 = lanes(101, 1);
            tick();
            check($sformatf("tbl%0d_enable", i), enable, tbl[i].exp_en);
            check($sformatf("tbl%0d_out_0", i), out_0, sel_row(tbl[i].exp_sel));
            check($sformatf("tbl%0d_out_1", i), out_1, '0);
            check($sformatf("tbl%0d_blocks", i), blocks_done, 16'(tbl[i].exp_bd));
        end
        s_valid = 1'b0;
        s_last  = 1'b0;

        // Underflow: stall holds out_0 with enable low.
        s_valid = 1'b1; s_data_0 = lanes(1, 1); s_last = 1'b0;
        tick();
        s_valid = 1'b0;
        tick();
        check("uf_first_en", enable, 1'b1);
        check("uf_first_out", out_0, lanes(1, 1));
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                s_valid = 1'b1; s_data_0 = lanes(9, 1); s_last = 1'b1;
            end
            tick();
            check($sformatf("uf_stall%0d_en", i), enable, 1'b0);
            check($sformatf("uf_stall%0d_hold", i), out_0, lanes(1, 1));
        end
        s_valid = 1'b0; s_last = 1'b0;
        tick();
        check("uf_resume_en", enable, 1'b1);
        check("uf_resume_out", out_0, lanes(9, 1));
        wait_idle();

        // Full FIFO while draining.
        mon_on = 1'b1;
        model_tile = 1'b0;
        s_valid = 1'b1; s_data_0 = lanes(200, 1); s_data_1 = lanes(300, 1); s_last = 1'b1;
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        tick();
        accepts = 0;
        for (int i = 0; i < 9; i++) begin
            s_valid  = 1'b1;
            s_data_0 = lanes(1000 + 16 * accepts, 1);
            s_data_1 = lanes(500, 3);
            s_last   = (accepts == 7);
            rdy = s_ready;
            if (i == 8) check("full_ready_low", rdy, 1'b0);
            if (rdy) accepts++;
            tick();
        end
        check("full_accepts", accepts, 8);
        check("full_ready_back", s_ready, 1'b1);
        check("full_pop_enable", enable, 1'b1);
        s_valid = 1'b0; s_last = 1'b0;
        wait_idle();

        // Tile switch requested mid-stream, applied after the drain.
        s_valid = 1'b1; s_data_0 = lanes(21, 1); s_data_1 = lanes(31, 1); s_last = 1'b0;
        tick();
        s_data_0 = lanes(41, 1);
        tick();
        tile_req = 1'b1;
        s_data_0 = lanes(51, 1); s_last = 1'b1;
        tick();
        check("ts_tile_stream", tile, 1'b0);
        s_valid = 1'b0; s_last = 1'b0;
        tick();
        model_tile = 1'b1;
        s_valid = 1'b1; s_data_0 = lanes(1, 1); s_data_1 = lanes(11, 11); s_last = 1'b1;
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("ts_tile_drain%0d", i), tile, 1'b0);
            tick();
        end
        check("ts_tile_set", tile, 1'b1);
        check("ts_last_drain_en", enable, 1'b1);
        for (int i = 0; i < HALF_SIZE; i++) begin
            tick();
            check($sformatf("ts_settle%0d_en", i), enable, 1'b0);
        end
        tick();
        check("ts_next_en", enable, 1'b1);
        check("ts_next_out_0", out_0, lanes(1, 1));
        check("ts_next_out_1", out_1, lanes(11, 11));
        wait_idle();

        // Randomized traffic in tile mode.
        for (int i = 0; i < 400; i++) begin
            s_valid  = ($urandom_range(0, 3) != 0);
            s_data_0 = {$urandom, $urandom, $urandom, $urandom};
            s_data_1 = {$urandom, $urandom, $urandom, $urandom};
            s_last   = ($urandom_range(0, 5) == 0);
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0;
        wait_idle();

        // Reset mid-stream discards everything, asynchronously.
        mon_on = 1'b0;
        for (int i = 0; i < 3; i++) send_row(lanes(60 + i, 1), lanes(70, 1), 1'b0);
        s_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("mr_enable", enable, 1'b0);
        check("mr_out_0", out_0, '0);
        check("mr_out_1", out_1, '0);
        check("mr_tile", tile, 1'b0);
        check("mr_blocks", blocks_done, '0);
        check("mr_busy", busy, 1'b0);
        check("mr_s_ready", s_ready, 1'b1);
        exp_q.delete();
        exp_blocks = 0;
        tile_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("mr_after_enable", enable, 1'b0);
        check("mr_after_busy", busy, 1'b0);

        // Pointer wrap: 20 single-row blocks.
        mon_on = 1'b1;
        model_tile = 1'b0;
        for (int i = 0; i < 20; i++) send_row(lanes(100 * i + 7, 1), lanes(9, 2), 1'b1);
        s_valid = 1'b0; s_last = 1'b0;
        wait_idle();
        check("wrap_blocks_done", blocks_done, 16'd20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
